// File: rtl/key_note_recorder.sv
// Purpose: record keypad press events into a small note buffer and play them back one note at a time.
// Latency: a press or start sampled at edge T is visible at T+1; each note lasts NOTE_TICKS cycles valid plus GAP_TICKS cycles silent.
// Backpressure: none; presses arriving while the buffer is full are dropped and flagged in a sticky overflow bit.
module key_note_recorder #(
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3,
  parameter int NOTE_TICKS = 16,
  parameter int GAP_TICKS  = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        key,
  input  logic              pressed,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  output logic [3:0]        note,
  output logic              note_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_NOTE = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [CNT_W-1:0] NOTE_LOAD = CNT_W'(NOTE_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_TICKS - 1);
  localparam logic [CNT_W-1:0] DUR_ONE   = CNT_W'(1);
  localparam logic [ADDR_W:0]  CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  dur;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_nxt;
  logic              pressed_q;
  logic [3:0]        mem [DEPTH];

  logic rise;
  logic abort;
  logic last;
  logic play_start;
  logic wr_en;

  // A held key only counts once: an event is the first cycle pressed is seen high.
  assign rise       = pressed & ~pressed_q;
  assign abort      = stop | clear;
  assign idx_nxt    = idx + IDX_ONE;
  assign last       = ({1'b0, idx} == (count - CNT_ONE));
  assign play_start = start & ~empty;
  // Recording only happens in IDLE and loses to clear and to an accepted start.
  assign wr_en      = (state == S_IDLE) & ~clear & ~play_start & rise & ~full;

  // DEPTH is a power of two and count never exceeds it, so the top bit alone means full.
  assign full       = count[ADDR_W];
  assign empty      = (count == '0);
  assign busy       = (state != S_IDLE);
  assign note_valid = (state == S_NOTE);

  // Press-edge history register, tracked in every state so presses during playback do not fire later.
  always_ff @(posedge clk) begin
    if (!rst_n) pressed_q <= 1'b0;
    else        pressed_q <= pressed;
  end

  // Note storage; contents survive reset and playback so the buffer can be replayed.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) mem[count[ADDR_W-1:0]] <= key;
  end

  // Control: record/clear in IDLE, timed note/gap sequencing during playback.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      dur      <= '0;
      idx      <= '0;
      note     <= 4'd0;
      done     <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (clear) begin
            count    <= '0;
            overflow <= 1'b0;
          end else if (play_start) begin
            idx   <= '0;
            note  <= mem[{ADDR_W{1'b0}}];
            dur   <= NOTE_LOAD;
            state <= S_NOTE;
          end else if (rise) begin
            if (!full) count    <= count + CNT_ONE;
            else       overflow <= 1'b1;
          end
        end
        S_NOTE, S_GAP: begin
          if (abort) begin
            state <= S_IDLE;
            done  <= 1'b1;
            if (clear) begin
              count    <= '0;
              overflow <= 1'b0;
            end
          end else if (dur != '0) begin
            dur <= dur - DUR_ONE;
          end else if (state == S_NOTE) begin
            state <= S_GAP;
            dur   <= GAP_LOAD;
          end else if (last) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end else begin
            idx   <= idx_nxt;
            note  <= mem[idx_nxt];
            dur   <= NOTE_LOAD;
            state <= S_NOTE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
